// File: rtl/bsg_sipo_pkg.sv
// Shared types and sizing helpers for the serial-in / parallel-out gatherer.
package bsg_sipo_pkg;

    typedef enum logic [0:0] {
        eFILL = 1'b0,
        eFULL = 1'b1
    } bsg_sipo_state_e;

    // Width of a counter that must hold every value from 0 up to els inclusive.
    function automatic int sipo_cnt_width(input int els);
        return $clog2(els + 1);
    endfunction

    localparam int sipo_default_els_lp       = 4;
    localparam int sipo_default_cnt_width_lp = sipo_cnt_width(sipo_default_els_lp);

endpackage

// File: rtl/bsg_dff_async_reset_en.sv
// Enabled register with asynchronous active-high clear; one instance per beat slice.
module bsg_dff_async_reset_en #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    // Capture on enable, otherwise hold; clear immediately on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r <= '0;
        end else if (en_i) begin
            data_r <= data_i;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_serial_in_parallel_out_full.sv
// Gathers els_p beats of width_p bits into one wide word offered on a valid/yumi
// interface. One bubble per word: no beat is taken while the full word is held.
module bsg_serial_in_parallel_out_full
    import bsg_sipo_pkg::*;
#(
    parameter int width_p    = 16,
    parameter int els_p      = 4,
    parameter int hi_to_lo_p = 0
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic [width_p-1:0]                 data_i,
    output logic                               v_o,
    output logic [width_p*els_p-1:0]           data_o,
    input  logic                               yumi_i,
    output logic [sipo_cnt_width(els_p)-1:0]   count_o
);

    localparam int cnt_width_lp = sipo_cnt_width(els_p);
    localparam logic [cnt_width_lp-1:0] last_lp = cnt_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(els_p);

    bsg_sipo_state_e           state_r;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic                      xfer;

    // Handshake outputs decode straight from the state flop; reset holds ready low.
    assign ready_and_o = (state_r == eFILL) & ~reset_i;
    assign v_o         = (state_r == eFULL);
    assign count_o     = cnt_r;
    assign xfer        = v_i & ready_and_o;

    // FSM and beat counter: count transfers up to els_p, wrap to 0 when the word is taken.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eFILL;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                eFILL: begin
                    if (xfer) begin
                        cnt_r <= cnt_r + cnt_width_lp'(1);
                        if (cnt_r == last_lp) begin
                            state_r <= eFULL;
                        end
                    end
                end
                eFULL: begin
                    if (yumi_i) begin
                        cnt_r   <= '0;
                        state_r <= eFILL;
                    end
                end
                default: begin
                    state_r <= eFILL;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // One slice register per beat; only the slice addressed by the counter loads.
    for (genvar i = 0; i < els_p; i++) begin : g_slice
        localparam int pos_lp = (hi_to_lo_p != 0) ? (els_p - 1 - i) : i;
        localparam logic [cnt_width_lp-1:0] idx_lp = cnt_width_lp'(i);

        bsg_dff_async_reset_en #(
            .width_p (width_p)
        ) u_slice (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (xfer & (cnt_r == idx_lp)),
            .data_i  (data_i),
            .data_o  (data_o[pos_lp*width_p +: width_p])
        );
    end

    // Consumer may only take a word that is actually held.
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");

    // The counter never runs past a full word.
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (reset_i) cnt_r <= full_lp)
        else $error("beat counter exceeded els_p");

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_full.sv
// Randomised bench for the SIPO gatherer: two instances (low-first and high-first
// slice order) share one stimulus and are compared every cycle against a beat-list model.
module tb_bsg_serial_in_parallel_out_full;

    localparam int W  = 16;
    localparam int E  = 4;
    localparam int CW = 3;
    localparam int DW = W * E;
    localparam int NWORDS = 100;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic          yumi_i;
    logic [W-1:0]  data_i;
    logic          rdy0, rdy1, v0, v1;
    logic [DW-1:0] d0, d1;
    logic [CW-1:0] c0, c1;

    always #5 clk = ~clk;

    bsg_serial_in_parallel_out_full #(.width_p(W), .els_p(E), .hi_to_lo_p(0)) dut_lo (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_and_o(rdy0), .data_i(data_i),
        .v_o(v0), .data_o(d0), .yumi_i(yumi_i), .count_o(c0)
    );

    bsg_serial_in_parallel_out_full #(.width_p(W), .els_p(E), .hi_to_lo_p(1)) dut_hi (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_and_o(rdy1), .data_i(data_i),
        .v_o(v1), .data_o(d1), .yumi_i(yumi_i), .count_o(c1)
    );

    int checks = 0;
    int errors = 0;
    int proto_err = 0;

    // Reference model: number of beats held and the last beat written to each position.
    int           m_cnt;
    logic [W-1:0] m_slot [E];

    logic [W-1:0]  beats [NWORDS*E];
    logic [DW-1:0] exp_words [NWORDS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_lo();
        logic [DW-1:0] w = '0;
        for (int k = 0; k < E; k++) w[k*W +: W] = m_slot[k];
        return w;
    endfunction

    function automatic logic [DW-1:0] word_hi();
        logic [DW-1:0] w = '0;
        for (int k = 0; k < E; k++) w[(E-1-k)*W +: W] = m_slot[k];
        return w;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int k = 0; k < E; k++) m_slot[k] = '0;
    endtask

    task automatic check_outs();
        chk("ready_lo", rdy0, (m_cnt < E) && !reset_i);
        chk("ready_hi", rdy1, (m_cnt < E) && !reset_i);
        chk("v_lo", v0, m_cnt == E);
        chk("v_hi", v1, m_cnt == E);
        chk("count_lo", c0, m_cnt);
        chk("count_hi", c1, m_cnt);
        chk("data_lo", d0, word_lo());
        chk("data_hi", d1, word_hi());
    endtask

    // Drive one cycle (called #1 after a rising edge), advance the model, check.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic y);
        logic take;
        logic consume;
        v_i    = v;
        data_i = d;
        yumi_i = y;
        take    = v && (m_cnt < E);
        consume = y && (m_cnt == E);
        @(posedge clk);
        #1;
        if (take) begin
            m_slot[m_cnt] = d;
            m_cnt++;
        end else if (consume) begin
            m_cnt = 0;
        end
        check_outs();
    endtask

    // Independent protocol watch: consumer strobes with no word held.
    always @(posedge clk) begin
        if (!reset_i && yumi_i && !v0) proto_err++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] b [E];
        int idx, words, last, cyc;
        logic y, vv;

        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        reset_i = 1'b0;
        #1;
        check_outs();
        @(posedge clk);
        #1;
        check_outs();

        // Basic word, both slice orders.
        cycle(1'b1, 16'h1111, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0);
        cycle(1'b1, 16'h3333, 1'b0);
        cycle(1'b1, 16'h4444, 1'b0);
        chk("basic_lo", d0, 64'h4444_3333_2222_1111);
        chk("basic_hi", d1, 64'h1111_2222_3333_4444);
        chk("basic_count", c0, 3'd4);

        // Backpressure: offered beats ignored while full.
        repeat (5) cycle(1'b1, 16'hAAAA, 1'b0);
        chk("bp_hold", d0, 64'h4444_3333_2222_1111);
        cycle(1'b1, 16'hAAAA, 1'b1);
        chk("bp_after_yumi_v", v0, 1'b0);
        chk("bp_after_yumi_ready", rdy0, 1'b1);
        cycle(1'b1, 16'hAAAA, 1'b0);
        chk("bp_beat0", d0[W-1:0], 16'hAAAA);
        for (int k = 1; k < E; k++) cycle(1'b1, W'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b1);

        // Gapped input: idle cycles between beats must not change the word.
        for (int wd = 0; wd < 3; wd++) begin
            for (int k = 0; k < E; k++) begin
                b[k] = W'($urandom);
                repeat ($urandom_range(0, 3)) cycle(1'b0, W'($urandom), 1'b0);
                cycle(1'b1, b[k], 1'b0);
            end
            chk("gap_word", d0, {b[3], b[2], b[1], b[0]});
            repeat ($urandom_range(0, 2)) cycle(1'b0, '0, 1'b0);
            cycle(1'b0, '0, 1'b1);
        end

        // Reset mid-word, pulsed between clock edges.
        cycle(1'b1, 16'hBEEF, 1'b0);
        cycle(1'b1, 16'hCAFE, 1'b0);
        v_i = 1'b0;
        #3;
        reset_i = 1'b1;
        #1;
        model_reset();
        check_outs();
        chk("rst_async_data", d0, 64'h0);
        #1;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        check_outs();
        for (int k = 0; k < E; k++) begin
            b[k] = W'($urandom);
            cycle(1'b1, b[k], 1'b0);
        end
        chk("rst_next_word", d0, {b[3], b[2], b[1], b[0]});
        cycle(1'b0, '0, 1'b1);

        // Streaming: continuous valid, consumer takes every word.
        for (int n = 0; n < NWORDS; n++) begin
            for (int k = 0; k < E; k++) begin
                beats[n*E + k] = W'($urandom);
                exp_words[n][k*W +: W] = beats[n*E + k];
            end
        end
        idx = 0; words = 0; last = 0; cyc = 0;
        while (words < NWORDS && cyc < 2000) begin
            y  = v0;
            vv = (idx < NWORDS*E);
            if (y) begin
                chk("stream_word", d0, exp_words[words]);
                if (words > 0) chk("stream_gap", cyc - last, 5);
                last = cyc;
                words++;
            end
            if (vv && rdy0) begin
                cycle(1'b1, beats[idx], y);
                idx++;
            end else begin
                cycle(vv, vv ? beats[idx] : '0, y);
            end
            cyc++;
        end
        chk("stream_done", words, NWORDS);
        chk("yumi_without_v", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_serial_in_parallel_out_full.md
# bsg_serial_in_parallel_out_full

Width-gathering stage that gathers `els_p` narrow beats of `width_p` bits into one wide word of `width_p*els_p` bits. It presents the wide word on a valid/yumi interface. It sits directly upstream of the wide enable-register stage: `v_o & yumi_i` is that stage's enable, and `data_o` is its data input. With the defaults it builds 64-bit words from 16-bit beats.

## Interface
- `width_p`, default 16: beat width in bits, ≥1.
- `els_p`, default 4: beats per word, ≥2.
- `hi_to_lo_p`, default 0: 0 places beat 0 in `data_o[width_p-1:0]`; 1 places beat 0 in the top slice.
- `clk_i`, input, 1: single clock; all state changes on its rising edge.
- `reset_i`, input, 1: asynchronous, active-high reset; the clock and reset port names are fixed.
- `v_i`, input, 1: a beat is offered.
- `ready_and_o`, output, 1: the block accepts a beat this cycle; a beat transfers when `v_i & ready_and_o`.
- `data_i`, input, `width_p`: the beat.
- `v_o`, output, 1: a full word is held.
- `data_o`, output, `width_p*els_p`: the assembled word.
- `yumi_i`, input, 1: the consumer takes the word this cycle; legal only when `v_o`=1.
- `count_o`, output, `$clog2(els_p+1)`: beats currently held (0..`els_p`), for debug and performance counters.

## Operation
- State machine `{FILL, FULL}`, plus a beat counter `cnt_r` of width `$clog2(els_p+1)`.
- FILL:
  - `ready_and_o`=1, `v_o`=0.
  - On a beat transfer: slice `cnt_r` captures `data_i` (placed according to `hi_to_lo_p`), and `cnt_r` increments.
  - When the transfer makes `cnt_r` reach `els_p`, the next state is FULL.
- FULL:
  - `ready_and_o`=0, `v_o`=1, and `data_o` is stable.
  - On `yumi_i`: `cnt_r`←0 and the next state is FILL. Slice registers are not cleared.
- `ready_and_o` and `v_o` are pure state decodes. No combinational path runs from `yumi_i` to `ready_and_o` or from `v_i` to `v_o`.
- Only the slice indexed by `cnt_r` is enabled on a transfer. Every other slice holds its value.
- `yumi_i` while `v_o`=0 is a protocol error:
  - The design ignores it.
  - The bench asserts on it.
- `v_i` held while `ready_and_o`=0 is legal. The upstream must hold `data_i` until it is accepted.
- Reset (asynchronous assertion, synchronous deassertion handled upstream):
  - `cnt_r`=0, state FILL, all slices 0.
  - Outputs: `data_o`=0, `v_o`=0, `count_o`=0.
  - `ready_and_o`=0 while `reset_i`=1, and 1 from the first cycle after deassertion.
- Reset mid-word (0<`cnt_r`<`els_p`): the partial word is discarded, with no output.
- Reset while FULL: the word is lost, even if `yumi_i` is asserted in the same cycle.

## Timing
- Latency: the word is valid (`v_o`=1) in the cycle after the transfer of beat `els_p`-1.
- Throughput: at most one word per `els_p`+1 cycles. There is one bubble per word, because `ready_and_o` is low in FULL and the consumed cycle's beat cannot be taken.
- `count_o` equals `cnt_r`: `els_p` in FULL, 0..`els_p`-1 in FILL.
- Counter wrap: after `yumi_i`, the count goes from `els_p` to 0. It never goes beyond `els_p`.
- All outputs are registered or decoded directly from flops, so the block is safe to place before a long wire to the downstream register.

## Structure
- Shared package `bsg_sipo_pkg`:
  - `typedef enum logic [0:0] {eFILL, eFULL} bsg_sipo_state_e`.
  - Localparam helpers for the counter width.
- One sub-module, `bsg_dff_async_reset_en`, instantiated `els_p` times (one per slice):
  - Width `width_p`, asynchronous active-high reset to 0, enable input.
  - Enable for slice `i` is `v_i & ready_and_o & (cnt_r==i)`.
- Top-level RTL holds the FSM, the counter, the slice-index mapping (`hi_to_lo_p`) and the protocol assertions.

## Test plan
- **Basic word:** after reset, send beats 16'h1111, 2222, 3333, 4444 back-to-back (`yumi_i`=0) → in the cycle after the 4th beat, `v_o`=1, `data_o`=64'h4444_3333_2222_1111, `count_o`=4, `ready_and_o`=0.
- **Order reversal:** repeat the basic word with `hi_to_lo_p`=1 → `data_o`=64'h1111_2222_3333_4444.
- **Backpressure:** hold FULL for 5 cycles with `v_i`=1 and `data_i`=16'hAAAA → `data_o` is unchanged and nothing is accepted. Assert `yumi_i` → the next cycle has `v_o`=0, `ready_and_o`=1, and 16'hAAAA is accepted as beat 0.
- **Gapped input:** insert random `v_i`=0 gaps between beats → `count_o` steps only on transfers, and the assembled word is identical to the gap-free word.
- **Reset mid-word:** after 2 beats, pulse `reset_i` asynchronously between clock edges → outputs go to 0 immediately, the next word starts at slice 0, and no stale data appears in it.
- **Streaming:** drive 100 random words with `yumi_i` asserted on every `v_o` → the scoreboard matches every word, throughput is exactly one word per 5 cycles, and the `yumi_i`-without-`v_o` assertion never fires.
